ram_stream_reader: RTL and testbench
====================================

Name: ram_stream_reader

Overview:
Read-side master for one port of the team's true dual-port block RAM; the other port is owned by the writer, e.g. a host or an Epiphany-side loader. On a start command it sweeps a contiguous, wrapping address range. It absorbs the RAM's fixed 1-cycle read latency and presents the words as a valid/ready stream with backpressure, at full throughput of 1 word/cycle. It is the drain path for result buffers after a cracking pass.

Parameters:
DATA_WIDTH, 32, RAM word width and stream data width
ADDR_WIDTH, 10, RAM address width; RAM depth is 2**ADDR_WIDTH

Ports:
clk  in  1  single clock; the RAM read port is clocked by the same clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle command strobe; honoured only in IDLE
base_addr  in  ADDR_WIDTH  first word address, sampled with start
word_count  in  ADDR_WIDTH+1  number of words, 0..2**ADDR_WIDTH, sampled with start
busy  out  1  command in progress
done  out  1  one-cycle pulse when the command completes
ram_addr  out  ADDR_WIDTH  read address to the RAM port; that port's write enable is tied low at top level
ram_rdata  in  DATA_WIDTH  RAM read data, valid 1 cycle after ram_addr
m_data  out  DATA_WIDTH  stream data, registered
m_valid  out  1  stream valid
m_last  out  1  marks the final word of the command
m_ready  in  1  stream ready from the sink

Behaviour:
- Reset (rst sampled high): state=IDLE; busy=0, done=0, m_valid=0, m_last=0, ram_addr=0, m_data=0; buffer and in-flight flag cleared. This applies at any time, including mid-command; no partial stream resumes afterwards.
- States and transitions:
  - IDLE: start, count>0 -> READ. start, count=0 -> DONE.
  - READ -> DRAIN on the cycle the last read issues.
  - DRAIN -> DONE on the last-word handshake.
  - DONE -> IDLE after 1 cycle.
- busy: 1 in READ and DRAIN.
- done: 1 only in DONE.
- start in any state other than IDLE is ignored.
- Issue rule:
  - In READ, a read issues in a cycle when occupancy + inflight - pop < 2, where pop = m_valid & m_ready.
  - Issuing means ram_addr = cur_addr this cycle, inflight is set for the next cycle, cur_addr increments, and the remaining count decrements.
  - ram_addr is combinational from cur_addr; a non-issuing cycle performs a harmless read.
- Address arithmetic: cur_addr = (base_addr + i) mod 2**ADDR_WIDTH. It wraps from 2**ADDR_WIDTH-1 to 0 with no error.
- Capture:
  - When inflight=1, ram_rdata is written into a 2-entry FIFO in that cycle.
  - The FIFO head drives m_data and m_valid.
  - Simultaneous push and pop are allowed; the FIFO can never overflow under the issue rule.
- m_last = m_valid and the head word is the word_count-th word. A tag bit is carried per FIFO entry.
- Latency: start sampled at cycle 0 -> first read cycle 1 -> data captured cycle 2 -> m_valid=1 from cycle 3.
- Throughput: with m_ready held high, N words occupy cycles 3..N+2 and done pulses at cycle N+3.
- Backpressure: m_data, m_valid and m_last stay stable while m_valid=1 and m_ready=0.
- word_count=2**ADDR_WIDTH reads every RAM word exactly once.
- word_count=0: DONE at cycle 1, no stream beat, busy never asserts.

Decomposition:
- Package ram_stream_pkg: state enum {IDLE, READ, DRAIN, DONE}; FIFO depth constant 2; count-width helper localparam (ADDR_WIDTH+1).
- One sub-module: ram_rd_skid_fifo, a 2-entry registered FIFO of {last, data} with push/pop/occupancy, synchronous reset.
- Top level: FSM, counters and issue logic, ~200 lines total.

Test Plan:
- RAM preloaded mem[i]=i*3; base=8, count=4, m_ready=1 -> data 24,27,30,33 on cycles 3..6; m_last on 33; done at cycle 7.
- base=1022, count=4 -> reads addresses 1022,1023,0,1 in order; data mem[1022],mem[1023],mem[0],mem[1].
- count=16, m_ready toggled pseudo-randomly -> 16 beats in order, no loss or duplicate, outputs stable while stalled, ≤2 reads outstanding plus buffered.
- count=0 -> done pulse at cycle 1, m_valid stays 0, busy stays 0; count=1024 -> 1024 beats, m_last only on the last.
- start pulsed again during READ with different base -> ignored; original stream completes unchanged.
- rst asserted mid-burst after 3 beats -> next cycle m_valid=0, busy=0; a new command then streams correctly from its own base.

Source files
------------

// File: rtl/ram_stream_pkg.sv
// Shared types and constants for the RAM stream reader.
package ram_stream_pkg;

  // Reader sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Capture buffer depth: one word per cycle of RAM latency plus one for a stalled sink.
  localparam int FIFO_DEPTH = 2;

  // Width of the capture buffer occupancy count (0..FIFO_DEPTH).
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  // Word counts run 0..2**aw inclusive, so they need one bit more than an address.
  function automatic int cnt_width(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/ram_rd_skid_fifo.sv
// Two-entry registered FIFO of {last, data}. Entry 0 is always the head, so the
// head outputs come straight from flops.
module ram_rd_skid_fifo
  import ram_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_last,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_last,
  output logic                  head_valid,
  output logic [OCC_W-1:0]      occupancy
);

  logic [DATA_WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
  logic                  last0_q, last0_d, last1_q, last1_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic                  do_pop;

  // A pop against an empty buffer is a no-op.
  assign do_pop = pop && (occ_q != '0);

  // Next entry contents and occupancy for push/pop combinations.
  always_comb begin
    data0_d = data0_q;
    data1_d = data1_q;
    last0_d = last0_q;
    last1_d = last1_q;
    occ_d   = occ_q;
    case (occ_q)
      OCC_W'(0): begin
        if (push) begin
          data0_d = push_data;
          last0_d = push_last;
          occ_d   = OCC_W'(1);
        end
      end
      OCC_W'(1): begin
        if (push && do_pop) begin
          data0_d = push_data;
          last0_d = push_last;
        end else if (push) begin
          data1_d = push_data;
          last1_d = push_last;
          occ_d   = OCC_W'(2);
        end else if (do_pop) begin
          occ_d   = OCC_W'(0);
        end
      end
      default: begin
        // Full: the reader never pushes here without a simultaneous pop.
        if (do_pop) begin
          data0_d = data1_q;
          last0_d = last1_q;
          if (push) begin
            data1_d = push_data;
            last1_d = push_last;
          end else begin
            occ_d   = OCC_W'(1);
          end
        end
      end
    endcase
  end

  // Entry and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      data0_q <= '0;
      data1_q <= '0;
      last0_q <= 1'b0;
      last1_q <= 1'b0;
      occ_q   <= '0;
    end else begin
      data0_q <= data0_d;
      data1_q <= data1_d;
      last0_q <= last0_d;
      last1_q <= last1_d;
      occ_q   <= occ_d;
    end
  end

  assign head_data  = data0_q;
  assign head_last  = last0_q;
  assign head_valid = (occ_q != '0);
  assign occupancy  = occ_q;

endmodule

// File: rtl/ram_stream_reader.sv
// Read-side master for one block-RAM port: sweeps a wrapping address range and
// presents the words as a valid/ready stream, hiding the 1-cycle read latency.
//
// state | meaning
// IDLE  | waiting for start
// READ  | issuing reads while the capture buffer has room
// DRAIN | all reads issued, waiting for the last-word handshake
// DONE  | one-cycle completion pulse
module ram_stream_reader
  import ram_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready
);

  localparam int CNT_W = cnt_width(ADDR_WIDTH);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [CNT_W-1:0]      remaining_q, remaining_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  pop;
  logic                  issue;
  logic                  head_last;
  logic [OCC_W-1:0]      fifo_occ;

  assign pop = m_valid && m_ready;

  // Issue only if the word could not overflow the buffer:
  // occupancy + inflight - pop < FIFO_DEPTH, rearranged to avoid underflow.
  assign issue = (state_q == READ) &&
                 (({1'b0, fifo_occ} + {{OCC_W{1'b0}}, inflight_q}) <
                  ((OCC_W+1)'(FIFO_DEPTH) + {{OCC_W{1'b0}}, pop}));

  // The RAM port always sees the current address; non-issuing cycles are harmless reads.
  assign ram_addr = cur_addr_q;

  // Next-state, address and count sequencing.
  always_comb begin
    state_d         = state_q;
    cur_addr_d      = cur_addr_q;
    remaining_d     = remaining_q;
    inflight_d      = issue;
    inflight_last_d = issue && (remaining_q == CNT_W'(1));
    case (state_q)
      IDLE: begin
        if (start) begin
          cur_addr_d  = base_addr;
          remaining_d = word_count;
          state_d     = (word_count == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (issue) begin
          cur_addr_d  = ADDR_WIDTH'(cur_addr_q + 1'b1);
          remaining_d = CNT_W'(remaining_q - 1'b1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && head_last) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == READ) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  // FSM, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      cur_addr_q      <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cur_addr_q      <= cur_addr_d;
      remaining_q     <= remaining_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  // Capture buffer: words land one cycle after their read issued.
  ram_rd_skid_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (inflight_q),
    .push_data  (ram_rdata),
    .push_last  (inflight_last_q),
    .pop        (pop),
    .head_data  (m_data),
    .head_last  (head_last),
    .head_valid (m_valid),
    .occupancy  (fifo_occ)
  );

  assign m_last = m_valid && head_last;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a behavioural RAM and a stream scoreboard.
module tb_ram_stream_reader;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   word_count = '0;
  logic          busy, done;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_rdata = '0;
  logic [DW-1:0] m_data;
  logic          m_valid, m_last;
  logic          m_ready = 1'b1;

  logic [DW-1:0] mem [DEPTH];
  logic [DW:0]   exp_q [$];

  int cmp_cnt = 0;
  int err_cnt = 0;
  int beat_cnt = 0;

  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .ram_addr   (ram_addr),
    .ram_rdata  (ram_rdata),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_last     (m_last),
    .m_ready    (m_ready)
  );

  always #5 clk = ~clk;

  // Same-clock RAM with 1-cycle read latency.
  always @(posedge clk) ram_rdata <= mem[ram_addr];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Sink-side monitor: pops the scoreboard on each handshake and checks stall stability.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, prev_data);
        check("stall_last", m_last, prev_last);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", exp_q.size(), 1);
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          check("beat_data", m_data, e[DW-1:0]);
          check("beat_last", m_last, e[DW]);
          beat_cnt++;
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  // Drive a command at the current negedge (cycle 0); returns at cycle 1.
  task automatic launch(input int base, input int count);
    logic [AW-1:0] a;
    start      = 1'b1;
    base_addr  = AW'(base);
    word_count = (AW+1)'(count);
    for (int i = 0; i < count; i++) begin
      a = AW'(base + i);
      exp_q.push_back({(i == count - 1), mem[a]});
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    bit got = 0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        got = 1;
        break;
      end
      if (rnd) m_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    check("done_seen", got, 1);
    m_ready = 1'b1;
    @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i * 3);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", m_valid, 0);
    check("rst_last", m_last, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_data", m_data, 0);
    rst = 1'b0;
    @(negedge clk);

    // Latency and throughput: base 8, count 4, sink always ready
    launch(8, 4);
    for (int k = 1; k <= 8; k++) begin
      check("t1_busy", busy, (k >= 1 && k <= 6));
      check("t1_valid", m_valid, (k >= 3 && k <= 6));
      check("t1_done", done, (k == 7));
      @(negedge clk);
    end
    check("t1_drained", exp_q.size(), 0);

    // Address wrap at the top of the RAM
    launch(1022, 4);
    wait_done(40, 0);

    // Random backpressure
    launch(100, 16);
    wait_done(400, 1);
    check("t3_beats", beat_cnt, 4 + 4 + 16);

    // Zero-length command
    launch(50, 0);
    check("t4_done_c1", done, 1);
    check("t4_busy_c1", busy, 0);
    check("t4_valid_c1", m_valid, 0);
    @(negedge clk);
    check("t4_done_c2", done, 0);
    check("t4_busy_c2", busy, 0);
    check("t4_valid_c2", m_valid, 0);

    // Full-RAM sweep from a non-zero base
    launch(5, DEPTH);
    wait_done(DEPTH + 50, 0);
    check("t4_full_beats", beat_cnt, 24 + DEPTH);

    // Start during READ is ignored
    launch(200, 8);
    @(negedge clk);
    start      = 1'b1;
    base_addr  = AW'(600);
    word_count = (AW+1)'(3);
    @(negedge clk);
    start = 1'b0;
    wait_done(60, 0);
    repeat (6) @(negedge clk);
    check("t5_idle_busy", busy, 0);
    check("t5_beats", beat_cnt, 24 + DEPTH + 8);

    // Reset mid-burst after 3 beats, then a fresh command
    beat_cnt = 0;
    m_ready  = 1'b1;
    launch(300, 10);
    for (int i = 0; i < 50 && beat_cnt < 3; i++) @(negedge clk);
    check("t6_three_beats", (beat_cnt >= 3), 1);
    rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    check("t6_rst_valid", m_valid, 0);
    check("t6_rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    beat_cnt = 0;
    launch(40, 5);
    wait_done(40, 0);
    check("t6_new_beats", beat_cnt, 5);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
